// File: rtl/data_mover_bram_mlp.sv
// rtl/data_mover_bram_mlp.sv - BRAM data mover computing 16 lane-wise unsigned MAC results
//
// data_mover_bram_mlp: streams N words from port A of nine BRAMs and accumulates
//   acc[4L+j] += x_j * w_Lj + b_Lj (b0 = x, b(2L+1) = weights, b(2L+2) = bias).
//   clk, reset_n          : clock, synchronous active-low reset
//   i_run, i_num_cnt      : start pulse (IDLE only) and word count
//   o_idle/o_read/o_write/o_done : state flags (IDLE/RUN/WRITE/DONE)
//   addr_bN/ce_bN/we_bN/d_bN/q_bN : BRAM port-A, N = 0..8 (read only)
//   result_0..result_15   : accumulated results, updated in WRITE
// true_dpbram: two-port RAM, 1-cycle read latency, q holds when ce=0.
`timescale 1ns/1ps
module data_mover_bram_mlp #(
   parameter int CNT_BIT       = 31,
   parameter int DWIDTH        = 32,
   parameter int AWIDTH        = 12,
   parameter int MEM_SIZE      = 4096,
   parameter int IN_DATA_WITDH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_read,
   output logic               o_write,
   output logic               o_done,
   output logic [AWIDTH-1:0]  addr_b0, addr_b1, addr_b2, addr_b3, addr_b4,
   output logic [AWIDTH-1:0]  addr_b5, addr_b6, addr_b7, addr_b8,
   output logic               ce_b0, ce_b1, ce_b2, ce_b3, ce_b4, ce_b5, ce_b6, ce_b7, ce_b8,
   output logic               we_b0, we_b1, we_b2, we_b3, we_b4, we_b5, we_b6, we_b7, we_b8,
   output logic [DWIDTH-1:0]  d_b0, d_b1, d_b2, d_b3, d_b4, d_b5, d_b6, d_b7, d_b8,
   input  logic [DWIDTH-1:0]  q_b0, q_b1, q_b2, q_b3, q_b4, q_b5, q_b6, q_b7, q_b8,
   output logic [DWIDTH-1:0]  result_0, result_1, result_2, result_3,
   output logic [DWIDTH-1:0]  result_4, result_5, result_6, result_7,
   output logic [DWIDTH-1:0]  result_8, result_9, result_10, result_11,
   output logic [DWIDTH-1:0]  result_12, result_13, result_14, result_15
);
   localparam int LANES = 4;
   localparam int NRES  = 16;
   localparam int NBRAM = 9;
   localparam int IW    = IN_DATA_WITDH;
   localparam int PW    = 2 * IN_DATA_WITDH;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_WRITE, S_DONE} state_t;

   state_t             state, next_state;
   logic [CNT_BIT-1:0] num_cnt, rd_cnt;
   logic [AWIDTH-1:0]  rd_addr;
   logic               rd_valid;
   logic               start;
   logic               last_rd;
   logic               ce;
   logic [AWIDTH-1:0]  addr;
   logic [DWIDTH-1:0]  q   [NBRAM];
   logic [DWIDTH-1:0]  acc [NRES];
   logic [DWIDTH-1:0]  mac [NRES];
   logic [DWIDTH-1:0]  res [NRES];

   assign q[0] = q_b0;  assign q[1] = q_b1;  assign q[2] = q_b2;
   assign q[3] = q_b3;  assign q[4] = q_b4;  assign q[5] = q_b5;
   assign q[6] = q_b6;  assign q[7] = q_b7;  assign q[8] = q_b8;

   assign start   = (state == S_IDLE) && i_run;
   assign last_rd = (rd_cnt == num_cnt - CNT_BIT'(1));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      o_idle     = 1'b0;
      o_read     = 1'b0;
      o_write    = 1'b0;
      o_done     = 1'b0;
      ce         = 1'b0;
      addr       = '0;
      case (state)
         S_IDLE: begin
            o_idle = 1'b1;
            // A zero count skips RUN entirely so no read is ever issued.
            if (i_run) next_state = (i_num_cnt == '0) ? S_FLUSH : S_RUN;
         end
         S_RUN: begin
            o_read = 1'b1;
            ce     = 1'b1;
            addr   = rd_addr;
            if (last_rd) next_state = S_FLUSH;
         end
         S_FLUSH: next_state = S_WRITE;
         S_WRITE: begin
            o_write    = 1'b1;
            next_state = S_DONE;
         end
         S_DONE: begin
            o_done     = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Lane j sits at bits [DWIDTH-1-IW*j -: IW]; layer L reads b(2L+1)/b(2L+2).
   always_comb begin
      for (int i = 0; i < NRES; i++) begin
         mac[i] = acc[i]
                + DWIDTH'(PW'(q[0][DWIDTH-1-IW*(i%LANES) -: IW])
                        * PW'(q[2*(i/LANES)+1][DWIDTH-1-IW*(i%LANES) -: IW]))
                + DWIDTH'(q[2*(i/LANES)+2][DWIDTH-1-IW*(i%LANES) -: IW]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         num_cnt  <= '0;
         rd_cnt   <= '0;
         rd_addr  <= '0;
         rd_valid <= 1'b0;
         for (int i = 0; i < NRES; i++) begin
            acc[i] <= '0;
            res[i] <= '0;
         end
      end else begin
         // Read data arrives one cycle after the address, so valid trails RUN.
         rd_valid <= (state == S_RUN);
         if (start) begin
            num_cnt <= i_num_cnt;
            rd_cnt  <= '0;
            rd_addr <= '0;
         end else if (state == S_RUN) begin
            rd_cnt  <= rd_cnt + CNT_BIT'(1);
            rd_addr <= (rd_addr == AWIDTH'(MEM_SIZE - 1)) ? '0 : rd_addr + AWIDTH'(1);
         end
         for (int i = 0; i < NRES; i++) begin
            if (start)         acc[i] <= '0;
            else if (rd_valid) acc[i] <= mac[i];
            if (state == S_WRITE) res[i] <= acc[i];
         end
      end
   end

   assign addr_b0 = addr; assign addr_b1 = addr; assign addr_b2 = addr;
   assign addr_b3 = addr; assign addr_b4 = addr; assign addr_b5 = addr;
   assign addr_b6 = addr; assign addr_b7 = addr; assign addr_b8 = addr;
   assign ce_b0 = ce; assign ce_b1 = ce; assign ce_b2 = ce; assign ce_b3 = ce; assign ce_b4 = ce;
   assign ce_b5 = ce; assign ce_b6 = ce; assign ce_b7 = ce; assign ce_b8 = ce;
   assign we_b0 = 1'b0; assign we_b1 = 1'b0; assign we_b2 = 1'b0; assign we_b3 = 1'b0;
   assign we_b4 = 1'b0; assign we_b5 = 1'b0; assign we_b6 = 1'b0; assign we_b7 = 1'b0;
   assign we_b8 = 1'b0;
   assign d_b0 = '0; assign d_b1 = '0; assign d_b2 = '0; assign d_b3 = '0; assign d_b4 = '0;
   assign d_b5 = '0; assign d_b6 = '0; assign d_b7 = '0; assign d_b8 = '0;

   assign result_0  = res[0];  assign result_1  = res[1];
   assign result_2  = res[2];  assign result_3  = res[3];
   assign result_4  = res[4];  assign result_5  = res[5];
   assign result_6  = res[6];  assign result_7  = res[7];
   assign result_8  = res[8];  assign result_9  = res[9];
   assign result_10 = res[10]; assign result_11 = res[11];
   assign result_12 = res[12]; assign result_13 = res[13];
   assign result_14 = res[14]; assign result_15 = res[15];
endmodule

module true_dpbram #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 12,
   parameter int MEM_SIZE = 4096
) (
   input  logic              clk,
   input  logic [AWIDTH-1:0] addr0,
   input  logic              ce0,
   input  logic              we0,
   input  logic [DWIDTH-1:0] d0,
   output logic [DWIDTH-1:0] q0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic              ce1,
   input  logic              we1,
   input  logic [DWIDTH-1:0] d1,
   output logic [DWIDTH-1:0] q1
);
   logic [DWIDTH-1:0] ram [MEM_SIZE];

   always_ff @(posedge clk) begin
      if (ce0) begin
         if (we0) ram[addr0] <= d0;
         else     q0 <= ram[addr0];
      end
      if (ce1) begin
         if (we1) ram[addr1] <= d1;
         else     q1 <= ram[addr1];
      end
   end
endmodule

// File: tb/tb_data_mover_bram_mlp.sv
// tb/tb_data_mover_bram_mlp.sv - self-checking bench for data_mover_bram_mlp
`timescale 1ns/1ps
module tb_data_mover_bram_mlp;
   localparam int DW = 32, AW = 12, CB = 31, MS = 4096, NB = 9, NR = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, i_run;
   logic [CB-1:0] i_num_cnt;
   logic          o_idle, o_read, o_write, o_done;
   logic [AW-1:0] addr_a [NB];
   logic          ce_a   [NB];
   logic          we_a   [NB];
   logic [DW-1:0] d_a    [NB];
   logic [DW-1:0] q_a    [NB];
   logic [DW-1:0] res    [NR];
   logic [AW-1:0] pb_addr;
   logic          pb_ce, pb_we;
   logic [DW-1:0] pb_d   [NB];
   logic [DW-1:0] pb_q   [NB];

   data_mover_bram_mlp dut (
      .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
      .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
      .addr_b0(addr_a[0]), .addr_b1(addr_a[1]), .addr_b2(addr_a[2]), .addr_b3(addr_a[3]),
      .addr_b4(addr_a[4]), .addr_b5(addr_a[5]), .addr_b6(addr_a[6]), .addr_b7(addr_a[7]),
      .addr_b8(addr_a[8]),
      .ce_b0(ce_a[0]), .ce_b1(ce_a[1]), .ce_b2(ce_a[2]), .ce_b3(ce_a[3]), .ce_b4(ce_a[4]),
      .ce_b5(ce_a[5]), .ce_b6(ce_a[6]), .ce_b7(ce_a[7]), .ce_b8(ce_a[8]),
      .we_b0(we_a[0]), .we_b1(we_a[1]), .we_b2(we_a[2]), .we_b3(we_a[3]), .we_b4(we_a[4]),
      .we_b5(we_a[5]), .we_b6(we_a[6]), .we_b7(we_a[7]), .we_b8(we_a[8]),
      .d_b0(d_a[0]), .d_b1(d_a[1]), .d_b2(d_a[2]), .d_b3(d_a[3]), .d_b4(d_a[4]),
      .d_b5(d_a[5]), .d_b6(d_a[6]), .d_b7(d_a[7]), .d_b8(d_a[8]),
      .q_b0(q_a[0]), .q_b1(q_a[1]), .q_b2(q_a[2]), .q_b3(q_a[3]), .q_b4(q_a[4]),
      .q_b5(q_a[5]), .q_b6(q_a[6]), .q_b7(q_a[7]), .q_b8(q_a[8]),
      .result_0(res[0]),   .result_1(res[1]),   .result_2(res[2]),   .result_3(res[3]),
      .result_4(res[4]),   .result_5(res[5]),   .result_6(res[6]),   .result_7(res[7]),
      .result_8(res[8]),   .result_9(res[9]),   .result_10(res[10]), .result_11(res[11]),
      .result_12(res[12]), .result_13(res[13]), .result_14(res[14]), .result_15(res[15])
   );

   for (genvar g = 0; g < NB; g++) begin : g_bram
      true_dpbram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) u_ram (
         .clk(clk),
         .addr0(addr_a[g]), .ce0(ce_a[g]), .we0(we_a[g]), .d0(d_a[g]), .q0(q_a[g]),
         .addr1(pb_addr), .ce1(pb_ce), .we1(pb_we), .d1(pb_d[g]), .q1(pb_q[g])
      );
   end

   typedef struct {
      int                   n;
      int                   mode;      // 0 sample, 1 all 0xFF, 2 random, 3 keep contents
      int                   exp_done;
      bit                   use_model;
      logic [15:0][31:0]    exp_r;
   } vec_t;

   logic [DW-1:0] mem     [NB][MS];
   logic [DW-1:0] exp_res [NR];
   logic [DW-1:0] held    [NR];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load_mem(input int n, input int mode);
      logic [DW-1:0] w;
      for (int a = 0; a < n; a++) begin
         @(negedge clk);
         for (int b = 0; b < NB; b++) begin
            if (mode == 1)      w = 32'hFFFF_FFFF;
            else if (mode == 2) w = $urandom;
            else if (a == 0 && b == 0) w = 32'h0102_0304;
            else if (a == 0 && b == 1) w = 32'h0101_0101;
            else                w = '0;
            mem[b][a] = w;
            pb_d[b]   = w;
         end
         pb_addr = AW'(a);
         pb_ce   = 1'b1;
         pb_we   = 1'b1;
      end
      @(negedge clk);
      pb_ce = 1'b0;
      pb_we = 1'b0;
   endtask

   // Reference: straight sum over the words, lane j = byte (3-j) counting from LSB.
   task automatic compute_model(input int n);
      int unsigned x, w, b;
      int a;
      for (int i = 0; i < NR; i++) exp_res[i] = '0;
      for (int k = 0; k < n; k++) begin
         a = k % MS;
         for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 4; j++) begin
               x = (mem[0][a]     >> (24 - 8*j)) & 32'hFF;
               w = (mem[2*l+1][a] >> (24 - 8*j)) & 32'hFF;
               b = (mem[2*l+2][a] >> (24 - 8*j)) & 32'hFF;
               exp_res[4*l+j] = exp_res[4*l+j] + x*w + b;
            end
         end
      end
   endtask

   task automatic run_case(input string name, input int n, input int exp_done,
                           input int pulse_at, input int rst_at);
      int  done_c = -1, ce_cnt = 0, seq_err = 0, hold_err = 0, late_done = 0;
      bit  aborted = 1'b0;
      @(negedge clk);
      check({name, "_idle_before_start"}, o_idle, 1);
      i_run     = 1'b1;
      i_num_cnt = CB'(n);
      for (int c = 1; c <= n + 10; c++) begin
         @(negedge clk);
         i_run     = (c == pulse_at);
         i_num_cnt = (c == pulse_at) ? CB'(3) : CB'($urandom);
         if (rst_at > 0 && c == rst_at) reset_n = 1'b0;
         if (rst_at > 0 && c == rst_at + 1) begin
            reset_n = 1'b1;
            aborted = 1'b1;
            check({name, "_rst_idle"}, o_idle, 1);
            check({name, "_rst_ce"}, ce_a[0], 0);
            for (int i = 0; i < NR; i++) if (res[i] !== '0) seq_err++;
            check({name, "_rst_results_zero"}, seq_err, 0);
         end
         if (aborted) begin
            if (o_done) late_done++;
         end else begin
            if (ce_a[0]) begin
               if (addr_a[0] !== AW'(ce_cnt % MS)) seq_err++;
               ce_cnt++;
            end
            for (int b = 0; b < NB; b++)
               if (ce_a[b] !== ce_a[0] || addr_a[b] !== addr_a[0] || we_a[b] !== 1'b0 || d_a[b] !== '0)
                  seq_err++;
            if (c == exp_done - 1 && rst_at == 0) check({name, "_write_flag"}, o_write, 1);
            if (o_done) begin
               done_c = c;
               break;
            end
            for (int i = 0; i < NR; i++) if (res[i] !== held[i]) hold_err++;
         end
      end
      if (aborted) begin
         check({name, "_no_done_after_reset"}, late_done, 0);
         for (int i = 0; i < NR; i++) held[i] = '0;
      end else begin
         check({name, "_done_cycle"}, done_c, exp_done);
         check({name, "_ce_count"}, ce_cnt, n);
         check({name, "_addr_seq"}, seq_err, 0);
         check({name, "_results_held"}, hold_err, 0);
      end
   endtask

   task automatic check_results(input string name);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("%s_result_%0d", name, i), res[i], exp_res[i]);
         held[i] = exp_res[i];
      end
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0].n = 1;    vecs[0].mode = 0; vecs[0].exp_done = 4;    vecs[0].use_model = 0;
      vecs[0].exp_r = '0;
      vecs[0].exp_r[0] = 1; vecs[0].exp_r[1] = 2; vecs[0].exp_r[2] = 3; vecs[0].exp_r[3] = 4;
      vecs[1].n = 4;    vecs[1].mode = 1; vecs[1].exp_done = 7;    vecs[1].use_model = 0;
      for (int i = 0; i < NR; i++) vecs[1].exp_r[i] = 32'd261120;
      vecs[2].n = 0;    vecs[2].mode = 3; vecs[2].exp_done = 3;    vecs[2].use_model = 0;
      vecs[2].exp_r = '0;
      vecs[3].n = 37;   vecs[3].mode = 2; vecs[3].exp_done = 40;   vecs[3].use_model = 1;
      vecs[3].exp_r = '0;
      vecs[4].n = 4096; vecs[4].mode = 2; vecs[4].exp_done = 4099; vecs[4].use_model = 1;
      vecs[4].exp_r = '0;
      vecs[5].n = 4200; vecs[5].mode = 3; vecs[5].exp_done = 4203; vecs[5].use_model = 1;
      vecs[5].exp_r = '0;

      reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0;
      pb_addr = '0; pb_ce = 1'b0; pb_we = 1'b0;
      for (int b = 0; b < NB; b++) pb_d[b] = '0;
      for (int i = 0; i < NR; i++) held[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_idle", o_idle, 1);
      check("reset_flags", {o_read, o_write, o_done}, 0);
      check("reset_ce_addr", {ce_a[0], addr_a[0]}, 0);
      begin
         int nz = 0;
         for (int i = 0; i < NR; i++) if (res[i] !== '0) nz++;
         check("reset_results", nz, 0);
      end
      reset_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].mode != 3) load_mem(vecs[v].n, vecs[v].mode);
         if (vecs[v].use_model) compute_model(vecs[v].n);
         else for (int i = 0; i < NR; i++) exp_res[i] = vecs[v].exp_r[i];
         run_case($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_done, 0, 0);
         check_results($sformatf("vec%0d", v));
      end

      compute_model(20);
      run_case("pulse_in_run", 20, 23, 5, 0);
      check_results("pulse_in_run");

      run_case("reset_mid_run", 50, 53, 0, 10);
      compute_model(50);
      run_case("after_reset", 50, 53, 0, 0);
      check_results("after_reset");

      compute_model(5);
      run_case("b2b_first", 5, 8, 0, 0);
      check_results("b2b_first");
      compute_model(8);
      run_case("b2b_second", 8, 11, 0, 0);
      check_results("b2b_second");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
